// File: rtl/seq_stream_checker.sv
// seq_stream_checker: locks onto a +STEP incrementing stream, then flags and counts deviations
module seq_stream_checker #(
   parameter int DATA_WIDTH = 4,
   parameter int STEP       = 1,
   parameter int LOCK_CNT   = 2,
   parameter int LOSS_CNT   = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  C,
   input  logic                  CLR,
   input  logic                  EN,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  RESYNC,
   output logic                  LOCKED,
   output logic                  ERR,
   output logic [DATA_WIDTH-1:0] EXP,
   output logic [CNT_WIDTH-1:0]  ERR_CNT,
   output logic [CNT_WIDTH-1:0]  SAMPLE_CNT
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;
   state_t state, state_nx;
   logic [MW-1:0] match, match_nx, match_inc;
   logic [LW-1:0] miss, miss_nx, miss_inc;
   logic [DATA_WIDTH-1:0] exp_nx;
   logic [CNT_WIDTH-1:0] err_cnt_nx, sample_cnt_nx;
   logic err_nx, hit, lost;
   assign LOCKED = state == LOCK;
   always_comb begin
      hit = D == EXP;
      match_inc = match + MW'(1);
      miss_inc = miss + LW'(1);
      lost = miss_inc == LW'(LOSS_CNT);
      state_nx = state;
      exp_nx = EXP;
      match_nx = match;
      miss_nx = miss;
      err_nx = 1'b0;
      err_cnt_nx = ERR_CNT;
      sample_cnt_nx = EN && ~&SAMPLE_CNT ? SAMPLE_CNT + CNT_WIDTH'(1) : SAMPLE_CNT;
      if (RESYNC) begin
         state_nx = HUNT;
         match_nx = '0;
         miss_nx = '0;
      end else if (EN) begin
         case (state)
            HUNT: begin
               exp_nx = D + STEP_W;
               match_nx = MW'(1);
               state_nx = LOCK_CNT == 1 ? LOCK : VERIFY;
            end
            VERIFY: begin
               exp_nx = D + STEP_W;
               match_nx = hit ? match_inc : MW'(1);
               state_nx = hit && match_inc == MW'(LOCK_CNT) ? LOCK : VERIFY;
            end
            LOCK: begin
               // on mismatch EXP keeps free-running so a single glitch does not shift the sequence
               exp_nx = EXP + STEP_W;
               err_nx = !hit;
               miss_nx = hit || lost ? '0 : miss_inc;
               err_cnt_nx = !hit && ~&ERR_CNT ? ERR_CNT + CNT_WIDTH'(1) : ERR_CNT;
               state_nx = !hit && lost ? HUNT : LOCK;
            end
            default: state_nx = HUNT;
         endcase
      end
   end
   always_ff @(posedge C) begin
      if (CLR) begin
         state <= HUNT;
         EXP <= '0;
         match <= '0;
         miss <= '0;
         ERR <= 1'b0;
         ERR_CNT <= '0;
         SAMPLE_CNT <= '0;
      end else begin
         state <= state_nx;
         EXP <= exp_nx;
         match <= match_nx;
         miss <= miss_nx;
         ERR <= err_nx;
         ERR_CNT <= err_cnt_nx;
         SAMPLE_CNT <= sample_cnt_nx;
      end
   end
endmodule

// File: tb/tb_seq_stream_checker.sv
// tb_seq_stream_checker: random and directed stream stimulus, scoreboard against a reference model
module tb_seq_stream_checker;
   logic C = 1'b0, CLR = 1'b1, EN = 1'b0, RESYNC = 1'b0;
   logic [3:0] D = '0;
   logic locked, err, locked2, err2;
   logic [3:0] exp_o, exp2;
   logic [15:0] err_cnt, sample_cnt;
   logic [1:0] err_cnt2, sample_cnt2;
   int checks = 0, errors = 0;
   logic [47:0] exp_q[$];
   int m_st, m_exp, m_match, m_miss, m_ec, m_sc, m_ec2, m_sc2;
   bit m_err;

   seq_stream_checker u_dut (.C(C), .CLR(CLR), .EN(EN), .D(D), .RESYNC(RESYNC), .LOCKED(locked),
      .ERR(err), .EXP(exp_o), .ERR_CNT(err_cnt), .SAMPLE_CNT(sample_cnt));
   seq_stream_checker #(.CNT_WIDTH(2)) u_sat (.C(C), .CLR(CLR), .EN(EN), .D(D), .RESYNC(RESYNC),
      .LOCKED(locked2), .ERR(err2), .EXP(exp2), .ERR_CNT(err_cnt2), .SAMPLE_CNT(sample_cnt2));

   always #5 C = ~C;

   // states: 0 hunt, 1 verify, 2 lock; LOCK_CNT=2, LOSS_CNT=3, step +1 mod 16
   function automatic void model(input bit clr, input bit en, input int d, input bit rs);
      if (clr) begin
         {m_st, m_exp, m_match, m_miss, m_ec, m_sc, m_ec2, m_sc2} = '0;
         m_err = 0;
         return;
      end
      m_err = 0;
      if (en) begin
         m_sc = m_sc < 65535 ? m_sc + 1 : m_sc;
         m_sc2 = m_sc2 < 3 ? m_sc2 + 1 : m_sc2;
      end
      if (rs) begin
         m_st = 0; m_match = 0; m_miss = 0;
      end else if (en) begin
         if (m_st == 0) begin
            m_exp = (d + 1) % 16; m_match = 1; m_st = 1;
         end else if (m_st == 1) begin
            m_match = d == m_exp ? m_match + 1 : 1;
            m_exp = (d + 1) % 16;
            if (m_match == 2) m_st = 2;
         end else if (d == m_exp) begin
            m_exp = (m_exp + 1) % 16; m_miss = 0;
         end else begin
            m_err = 1;
            m_exp = (m_exp + 1) % 16;
            m_ec = m_ec < 65535 ? m_ec + 1 : m_ec;
            m_ec2 = m_ec2 < 3 ? m_ec2 + 1 : m_ec2;
            m_miss++;
            if (m_miss == 3) begin m_st = 0; m_miss = 0; end
         end
      end
   endfunction

   task automatic step(input bit clr, input bit en, input logic [3:0] d, input bit rs);
      CLR = clr; EN = en; D = d; RESYNC = rs;
      model(clr, en, int'(d), rs);
      exp_q.push_back({m_st == 2, m_err, 4'(m_exp), 16'(m_ec), 16'(m_sc),
                       m_st == 2, m_err, 4'(m_exp), 2'(m_ec2), 2'(m_sc2)});
      @(posedge C); #1;
   endtask

   task automatic seq(input logic [3:0] d[$]);
      foreach (d[i]) step(0, 1, d[i], 0);
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge C) begin
      logic [47:0] act, req;
      if (exp_q.size() > 0) begin
         req = exp_q.pop_front();
         act = {locked, err, exp_o, err_cnt, sample_cnt, locked2, err2, exp2, err_cnt2, sample_cnt2};
         checks++;
         if (act !== req) begin
            errors++;
            $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, req);
         end
      end
   end

   initial begin
      step(1, 1, 4'h5, 0); step(1, 1, 4'h5, 0);
      check("reset", {locked, err, exp_o, err_cnt, sample_cnt}, 0);
      seq('{4'hD, 4'hE, 4'hF, 4'h0, 4'h1});
      check("wrap_locked", locked, 1); check("wrap_exp", exp_o, 2);
      check("wrap_samples", sample_cnt, 5); check("wrap_errs", err_cnt, 0);
      step(1, 0, 0, 0);
      seq('{4'h5, 4'h6, 4'h9});
      check("glitch_err", err, 1);
      seq('{4'h8, 4'h9});
      check("glitch_errcnt", err_cnt, 1); check("glitch_locked", locked, 1); check("glitch_exp", exp_o, 4'hA);
      step(1, 0, 0, 0);
      seq('{4'h1, 4'h2, 4'h7, 4'h7, 4'h7});
      check("loss_locked", locked, 0); check("loss_errcnt", err_cnt, 3);
      seq('{4'h2, 4'h3});
      check("relock", locked, 1); check("relock_errcnt", err_cnt, 3);
      step(1, 0, 0, 0);
      seq('{4'h1, 4'h2});
      repeat (4) step(0, 0, 4'hF, 0);
      check("gap_err", err, 0); check("gap_samples", sample_cnt, 2);
      seq('{4'h3});
      check("gap_locked", locked, 1);
      step(0, 1, 4'h0, 1);
      check("resync_locked", locked, 0); check("resync_samples", sample_cnt, 4); check("resync_exp", exp_o, 4);
      step(1, 1, 4'h4, 0);
      check("clr_mid", {locked, err, exp_o, err_cnt, sample_cnt}, 0);
      seq('{4'h1, 4'h2, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h8, 4'h0});
      check("sat_errcnt2", err_cnt2, 3); check("sat_samples2", sample_cnt2, 3);
      check("sat_errcnt", err_cnt, 5); check("sat_locked", locked, 1);
      repeat (3000) begin
         logic [3:0] d;
         d = $urandom_range(0, 9) < 7 ? 4'(m_exp) : 4'($urandom_range(0, 15));
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, d, $urandom_range(0, 99) < 3);
      end
      repeat (3) @(negedge C);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
